// File: rtl/step_unbuffer.sv
// ---------------------------------------------------------------------------
// step_unbuffer: complementary per-lane delay that realigns the staggered
// accumulator lanes. Macro STEP_UNBUFFER_CHECK_EN adds the misalignment checker.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module step_unbuffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int STEPS             = 4,
  parameter int ACCUMULATOR_DELAY = 4,
  parameter int TUSER_WIDTH       = 8
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic                                    aclken,
  input  logic                                    is_1x1,
  input  logic [STEPS-1:0]                        s_valid,
  input  logic [STEPS-1:0][DATA_WIDTH-1:0]        s_data,
  input  logic [STEPS-1:0]                        s_last,
  input  logic [STEPS-1:0][TUSER_WIDTH-1:0]       s_user,
  output logic [STEPS-1:0]                        m_valid,
  output logic [STEPS-1:0][DATA_WIDTH-1:0]        m_data,
  output logic [STEPS-1:0]                        m_last,
  output logic [STEPS-1:0][TUSER_WIDTH-1:0]       m_user,
  output logic                                    m_all_valid,
  output logic                                    err_misalign
);

  localparam int D    = ACCUMULATOR_DELAY - 2;
  localparam int SMAX = (STEPS - 1) * D + 1;
  localparam int BW   = DATA_WIDTH + TUSER_WIDTH + 2;
  localparam int VB   = BW - 1;
  localparam int LB   = BW - 2;

  // Beat layout inside the delay lines: {valid, last, user, data}
  logic [STEPS-1:0][BW-1:0] beat_sel;
  logic [STEPS-1:0][BW-1:0] out_q;

  for (genvar i = 0; i < STEPS; i++) begin : g_lane
    localparam int LEN = (i == 0) ? SMAX : (STEPS - 1 - i) * D;

    logic [BW-1:0] beat_in;
    logic [BW-1:0] tap_normal;
    logic [BW-1:0] tap_1x1;

    assign beat_in = {s_valid[i], s_last[i], s_user[i], s_data[i]};

    if (LEN > 0) begin : g_line
      logic [BW-1:0] line_q [LEN];

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          for (int k = 0; k < LEN; k++) line_q[k] <= '0;
        end else if (aclken) begin
          line_q[0] <= beat_in;
          for (int k = 1; k < LEN; k++) line_q[k] <= line_q[k-1];
        end
      end

      assign tap_normal = line_q[LEN-1];

      // Only lane 0 keeps a single stage in 1x1 mode; the others bypass.
      if (i == 0) begin : g_tap_first
        assign tap_1x1 = line_q[0];
      end else begin : g_tap_bypass
        assign tap_1x1 = beat_in;
      end
    end else begin : g_no_line
      assign tap_normal = beat_in;
      assign tap_1x1    = beat_in;
    end

    assign beat_sel[i] = is_1x1 ? tap_1x1 : tap_normal;

    assign m_valid[i] = out_q[i][VB];
    assign m_last[i]  = out_q[i][LB];
    assign m_user[i]  = out_q[i][DATA_WIDTH +: TUSER_WIDTH];
    assign m_data[i]  = out_q[i][DATA_WIDTH-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q <= '0;
    end else if (aclken) begin
      out_q <= beat_sel;
    end
  end

  assign m_all_valid = &m_valid;

`ifdef STEP_UNBUFFER_CHECK_EN
  localparam int MW = $clog2(SMAX + 2);

  logic          mode_q;
  logic [MW-1:0] mask_q;
  logic          err_q;
  logic          mode_chg;
  logic          misaligned;

  assign mode_chg = (is_1x1 != mode_q);

  // Judged on the beats about to be registered so the flag rises together
  // with the offending output cycle.
  always_comb begin
    misaligned = 1'b0;
    for (int i = 1; i < STEPS; i++) begin
      if (beat_sel[i][VB] != beat_sel[0][VB]) misaligned = 1'b1;
      if (beat_sel[i][VB] && (beat_sel[i][LB] != beat_sel[0][LB])) misaligned = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q <= 1'b0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else if (aclken) begin
      mode_q <= is_1x1;
      if (mode_chg) begin
        mask_q <= MW'(SMAX + 1);
      end else if (mask_q != '0) begin
        mask_q <= mask_q - MW'(1);
      end
      if ((mask_q == '0) && !mode_chg && misaligned) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_misalign = err_q;
`else
  assign err_misalign = 1'b0;
`endif

endmodule

`default_nettype wire
